// File: rtl/wave_sample_player.sv
// rtl/wave_sample_player.sv - multi-channel PCM sample player with wave-store fetch and saturating mixer
module wave_sample_player #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 20,
  parameter int LEN_W    = 16,
  parameter int RATE_DIV = 2177
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        trig,
  input  logic [NUM_CH-1:0]        loop_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_start,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [15:0]              mem_data,
  input  logic                     mem_valid,
  output logic [15:0]              mix_out,
  output logic [NUM_CH-1:0]        busy,
  output logic                     overrun
);

  // Channel index counts 0..NUM_CH inclusive; per-channel state is padded to a
  // power of two so the index always addresses a real (possibly idle) slot.
  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int SLOTS = 1 << CH_W;
  localparam int RC_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [RC_W-1:0]     rate_cnt;
  logic                tick;
  logic [NUM_CH-1:0]   trig_q;
  logic [CH_W-1:0]     ch;
  logic signed [17:0]  acc;
  logic [15:0]         sat_val;
  logic                restart_hit;
  logic                scan_end;
  logic                advance;

  logic [SLOTS-1:0]    trig_ld;
  logic [SLOTS-1:0]    loop_s;
  logic [SLOTS-1:0]    busy_s;
  logic [ADDR_W-1:0]   start_s [SLOTS];
  logic [LEN_W-1:0]    len_s   [SLOTS];
  logic [ADDR_W-1:0]   ptr     [SLOTS];
  logic [LEN_W-1:0]    cnt     [SLOTS];

  always_comb begin
    trig_ld = '0;
    loop_s  = '0;
    for (int n = 0; n < SLOTS; n++) begin
      start_s[n] = '0;
      len_s[n]   = '0;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      start_s[n] = ch_start[n*ADDR_W +: ADDR_W];
      len_s[n]   = ch_len[n*LEN_W +: LEN_W];
      loop_s[n]  = loop_en[n];
      trig_ld[n] = trig[n] & ~trig_q[n] & (ch_len[n*LEN_W +: LEN_W] != '0);
    end
  end

  assign scan_end = (ch == CH_W'(NUM_CH));
  assign busy     = busy_s[NUM_CH-1:0];
  assign mem_rd   = (state == S_ISSUE);
  // A restart that lands while its channel is being fetched must not be undone by the advance.
  assign advance  = (state == S_WAIT) && mem_valid && !restart_hit;

  always_comb begin
    if (acc > 18'sd32767) begin
      sat_val = 16'h7FFF;
    end else if (acc < -18'sd32768) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = acc[15:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick) state_nx = S_SCAN;
      S_SCAN: begin
        if (scan_end) begin
          state_nx = S_OUT;
        end else if (busy_s[ch]) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mem_valid) state_nx = S_SCAN;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      rate_cnt    <= '0;
      tick        <= 1'b0;
      // Capturing the live level means a trigger held through reset is not seen as an edge.
      trig_q      <= trig;
      ch          <= '0;
      acc         <= '0;
      mem_addr    <= '0;
      mix_out     <= '0;
      overrun     <= 1'b0;
      restart_hit <= 1'b0;
      busy_s      <= '0;
      for (int n = 0; n < SLOTS; n++) begin
        ptr[n] <= '0;
        cnt[n] <= '0;
      end
    end else begin
      state  <= state_nx;
      trig_q <= trig;

      if (rate_cnt == RC_W'(RATE_DIV - 1)) begin
        rate_cnt <= '0;
        tick     <= 1'b1;
      end else begin
        rate_cnt <= rate_cnt + RC_W'(1);
        tick     <= 1'b0;
      end

      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (tick) begin
            ch  <= '0;
            acc <= '0;
          end
        end
        S_SCAN: begin
          restart_hit <= trig_ld[ch];
          if (!scan_end) begin
            if (busy_s[ch]) begin
              mem_addr <= ptr[ch];
            end else begin
              ch <= ch + CH_W'(1);
            end
          end
        end
        S_ISSUE: restart_hit <= restart_hit | trig_ld[ch];
        S_WAIT: begin
          restart_hit <= restart_hit | trig_ld[ch];
          if (mem_valid) begin
            acc <= acc + {{2{mem_data[15]}}, mem_data};
            ch  <= ch + CH_W'(1);
          end
        end
        S_OUT:   mix_out <= sat_val;
        default: ;
      endcase

      for (int n = 0; n < SLOTS; n++) begin
        if (trig_ld[n]) begin
          ptr[n]    <= start_s[n];
          cnt[n]    <= len_s[n];
          busy_s[n] <= 1'b1;
        end else if (advance && (ch == CH_W'(n))) begin
          if ((cnt[n] == LEN_W'(1)) && loop_s[n] && (len_s[n] != '0)) begin
            ptr[n] <= start_s[n];
            cnt[n] <= len_s[n];
          end else begin
            ptr[n] <= ptr[n] + ADDR_W'(1);
            cnt[n] <= cnt[n] - LEN_W'(1);
            if (cnt[n] == LEN_W'(1)) begin
              busy_s[n] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_sample_player.sv
// tb/tb_wave_sample_player.sv - directed scoreboard bench for wave_sample_player
module tb_wave_sample_player;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 20;
  localparam int LEN_W  = 16;
  localparam int R      = 40;

  logic                     clk_sys = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        trig;
  logic [NUM_CH-1:0]        loop_en;
  logic [NUM_CH*ADDR_W-1:0] ch_start;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd;
  logic [15:0]              mem_data;
  logic                     mem_valid;
  logic [15:0]              mix_out;
  logic [NUM_CH-1:0]        busy;
  logic                     overrun;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int mem_lat  = 4;
  int extra_rd = 0;

  logic [15:0]       mix_q  [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [15:0]       wave_mem [int];

  wave_sample_player #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .RATE_DIV(R)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .trig     (trig),
    .loop_en  (loop_en),
    .ch_start (ch_start),
    .ch_len   (ch_len),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .mem_valid(mem_valid),
    .mix_out  (mix_out),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Phase reference: cycles since reset release equals the rate counter modulo R.
  always @(posedge clk_sys) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto_phase(input int p);
    do @(negedge clk_sys); while ((cyc % R) != p);
  endtask

  task automatic step(input string tag);
    logic [15:0] e;
    goto_phase(R - 2);
    if (mix_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=queue_empty", tag, mix_out);
    end else begin
      e = mix_q.pop_front();
      chk(tag, 32'(mix_out), 32'(e));
    end
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m, input int p);
    goto_phase(p);
    trig = trig | m;
    @(negedge clk_sys);
    trig = trig & ~m;
  endtask

  task automatic set_ch(input int n, input logic [ADDR_W-1:0] s, input logic [LEN_W-1:0] l);
    ch_start[n*ADDR_W +: ADDR_W] = s;
    ch_len[n*LEN_W +: LEN_W]     = l;
  endtask

  // Wave-store model: answers each read strobe after mem_lat cycles and checks the address.
  initial begin
    logic [ADDR_W-1:0] a;
    int                lat;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk_sys);
      if (mem_rd === 1'b1) begin
        a   = mem_addr;
        lat = mem_lat;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_fetch observed=%0h expected=none", a);
        end else begin
          chk("fetch_addr", 32'(a), 32'(addr_q.pop_front()));
        end
        for (int i = 0; i < lat; i++) begin
          @(negedge clk_sys);
          if (mem_rd === 1'b1) extra_rd++;
        end
        mem_data  = wave_mem.exists(int'(a)) ? wave_mem[int'(a)] : 16'h0000;
        mem_valid = 1'b1;
        @(negedge clk_sys);
        mem_valid = 1'b0;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    trig     = '0;
    loop_en  = '0;
    ch_start = '0;
    ch_len   = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_mix", 32'(mix_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Single channel, three samples, then silence.
    set_ch(0, 20'h00100, 16'd3);
    wave_mem[32'h100] = 16'h1000;
    wave_mem[32'h101] = 16'h2000;
    wave_mem[32'h102] = 16'h3000;
    addr_q.push_back(20'h00100); addr_q.push_back(20'h00101); addr_q.push_back(20'h00102);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h1000); mix_q.push_back(16'h2000);
    mix_q.push_back(16'h3000); mix_q.push_back(16'h0000);
    pulse(4'b0001, R - 5);
    step("t1_mix0");
    step("t1_mix1");
    chk("t1_busy_playing", 32'(busy), 32'h1);
    step("t1_mix2");
    step("t1_mix3");
    chk("t1_busy_done", 32'(busy), 32'h0);
    step("t1_mix_idle");

    // Two channels summing past both rails.
    set_ch(0, 20'h00200, 16'd2);
    set_ch(1, 20'h00300, 16'd2);
    wave_mem[32'h200] = 16'h7000; wave_mem[32'h201] = 16'h9000;
    wave_mem[32'h300] = 16'h7000; wave_mem[32'h301] = 16'h9000;
    addr_q.push_back(20'h00200); addr_q.push_back(20'h00300);
    addr_q.push_back(20'h00201); addr_q.push_back(20'h00301);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h7FFF);
    mix_q.push_back(16'h8000); mix_q.push_back(16'h0000);
    pulse(4'b0011, R - 5);
    step("t2_mix0");
    step("t2_sat_pos");
    step("t2_sat_neg");
    step("t2_mix_idle");
    chk("t2_busy_done", 32'(busy), 32'h0);

    // Looping channel across the top of the address space.
    set_ch(0, 20'hFFFFF, 16'd2);
    loop_en = 4'b0001;
    wave_mem[32'hFFFFF] = 16'h0123;
    wave_mem[32'h00000] = 16'h0456;
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(20'hFFFFF);
      addr_q.push_back(20'h00000);
    end
    mix_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      mix_q.push_back(16'h0123);
      mix_q.push_back(16'h0456);
    end
    mix_q.push_back(16'h0000);
    pulse(4'b0001, R - 5);
    for (int i = 0; i < 5; i++) step("t3_loop_mix");
    chk("t3_busy_looping", 32'(busy), 32'h1);
    loop_en = '0;
    for (int i = 0; i < 3; i++) step("t3_unloop_mix");
    chk("t3_busy_done", 32'(busy), 32'h0);

    // Restart of ch1 while its third sample is in flight.
    set_ch(1, 20'h00400, 16'd3);
    wave_mem[32'h400] = 16'h0010;
    wave_mem[32'h401] = 16'h0020;
    wave_mem[32'h402] = 16'h0030;
    addr_q.push_back(20'h00400); addr_q.push_back(20'h00401); addr_q.push_back(20'h00402);
    addr_q.push_back(20'h00400); addr_q.push_back(20'h00401); addr_q.push_back(20'h00402);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h0010); mix_q.push_back(16'h0020);
    pulse(4'b0010, R - 5);
    step("t4_mix0");
    step("t4_mix1");
    step("t4_mix2");
    mix_q.push_back(16'h0030); mix_q.push_back(16'h0010); mix_q.push_back(16'h0020);
    mix_q.push_back(16'h0030); mix_q.push_back(16'h0000);
    pulse(4'b0010, 5);
    for (int i = 0; i < 5; i++) step("t4_restart_mix");
    chk("t4_busy_done", 32'(busy), 32'h0);
    chk("t4_overrun_clear", 32'(overrun), 32'h0);

    // Slow memory forces an overrun; a zero-length trigger is ignored.
    set_ch(0, 20'h00500, 16'd1);
    set_ch(2, 20'h00800, 16'd0);
    wave_mem[32'h500] = 16'h0777;
    mem_lat  = R + 10;
    extra_rd = 0;
    addr_q.push_back(20'h00500);
    mix_q.push_back(16'h0000);
    pulse(4'b0101, R - 5);
    step("t5_mix0");
    chk("t5_zero_len_busy", 32'(busy), 32'h1);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h0777); mix_q.push_back(16'h0000);
    step("t5_mix_pending");
    step("t5_mix_late");
    step("t5_mix_idle");
    chk("t5_overrun", 32'(overrun), 32'h1);
    chk("t5_single_rd", 32'(extra_rd), 32'h0);
    mem_lat = 4;

    // Reset during a fetch, with a trigger held high across it.
    set_ch(0, 20'h00600, 16'd2);
    set_ch(3, 20'h00700, 16'd1);
    wave_mem[32'h600] = 16'h1111;
    wave_mem[32'h601] = 16'h2222;
    addr_q.push_back(20'h00600); addr_q.push_back(20'h00601);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h1111);
    pulse(4'b0001, R - 5);
    step("t6_mix0");
    step("t6_mix1");
    goto_phase(3);
    trig[3] = 1'b1;
    goto_phase(4);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("t6_rst_mix", 32'(mix_out), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_overrun", 32'(overrun), 32'h0);
    chk("t6_rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("t6_rst_mem_addr", 32'(mem_addr), 32'h0);
    mix_q.push_back(16'h0000); mix_q.push_back(16'h0000);
    step("t6_mix_after_rst");
    step("t6_mix_next");
    chk("t6_held_trig_busy", 32'(busy), 32'h0);
    trig = '0;

    chk("end_addr_q_empty", 32'(addr_q.size()), 32'h0);
    chk("end_mix_q_empty", 32'(mix_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
